apb_target_stream_fifo: RTL

//  APB target on the apb_processor request bus, decoded by paddr[31:28] like the timer/gpio targets.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_target_stream_fifo_pkg.sv | 35 +++
 rtl/apb_target_stream_fifo_fifo_sync_32.sv | 90 +++++++++
 rtl/apb_target_stream_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB bus typedefs used by the apb_processor targets.
package apb_pkg;

    // Request bundle driven by the APB master.
    typedef struct packed {
        logic [31:0] paddr;
        logic        penable;
        logic        psel;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_request_t;

    // Response bundle returned by a target.
    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        perr;
    } apb_response_t;

endpackage

// File: rtl/apb_target_stream_fifo_pkg.sv
// Register map and bit positions for the APB stream FIFO target.
package apb_target_stream_fifo_pkg;

    // Register select, taken from paddr[3:2].
    typedef enum logic [1:0] {
        REG_DATA      = 2'd0,
        REG_STATUS    = 2'd1,
        REG_CONTROL   = 2'd2,
        REG_THRESHOLD = 2'd3
    } reg_sel_e;

    // CONTROL register bits (write only, self-clearing actions).
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    // STATUS register bit positions.
    localparam int STATUS_OVF_BIT   = 31;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_EMPTY_BIT = 16;

    // Assemble the STATUS word from its fields.
    function automatic logic [31:0] status_word(input logic       overflow,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [7:0] level);
        logic [31:0] w;
        w                   = 32'd0;
        w[STATUS_OVF_BIT]   = overflow;
        w[STATUS_FULL_BIT]  = full;
        w[STATUS_EMPTY_BIT] = empty;
        w[7:0]              = level;
        return w;
    endfunction

endpackage

// File: rtl/apb_target_stream_fifo_fifo_sync_32.sv
// fifo_sync_32: single-clock 32-bit FIFO with push/pop/flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head word is read combinationally so the stream consumer sees it with
// no latency; storage is therefore a register/distributed array.
module fifo_sync_32 #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] head_data,
    output logic        full,
    output logic        empty,
    output logic [7:0]  level,
    output logic [7:0]  level_next
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] diff_now;
    logic [PW-1:0] diff_next;
    logic [31:0]   mem [DEPTH];
    logic          pop_fire;
    logic          push_fire;
    logic          write_en;

    assign empty     = (wptr_reg == rptr_reg);
    assign full      = ((wptr_reg ^ rptr_reg) == {1'b1, {DEPTH_LOG2{1'b0}}});
    assign pop_fire  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_fire = push && (!full || pop_fire);
    assign write_en  = en && push_fire && !flush;

    // Next-state pointers; flush overrides any pop in the same cycle.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (en) begin
            if (flush) begin
                wptr_next = '0;
                rptr_next = '0;
            end else begin
                if (push_fire) wptr_next = wptr_reg + 1'b1;
                if (pop_fire)  rptr_next = rptr_reg + 1'b1;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

    // One storage word per slot, written when the write pointer addresses it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the pushed word into this slot.
            always_ff @(posedge clk) begin
                if (write_en && (wptr_reg[DEPTH_LOG2-1:0] == DEPTH_LOG2'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Head word is forced to 0 when empty so stale slots never leak out.
    assign head_data = empty ? 32'd0 : mem[rptr_reg[DEPTH_LOG2-1:0]];

    // Level differences are taken at pointer width so the wrap works, then widened.
    assign diff_now   = wptr_reg - rptr_reg;
    assign diff_next  = wptr_next - rptr_next;
    assign level      = {{(8-PW){1'b0}}, diff_now};
    assign level_next = {{(8-PW){1'b0}}, diff_next};

endmodule

// File: rtl/apb_target_stream_fifo.sv
// apb_target_stream_fifo: APB target that buffers written words into a FIFO
// and drains them to a valid/ack stream consumer.
// Build option: APB_STREAM_FIFO_WAIT_STATE_EN -- when defined, a DATA write
// to a full FIFO stalls with pready=0 instead of being dropped.
module apb_target_stream_fifo
    import apb_pkg::*;
    import apb_target_stream_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic [31:0] apb_request__paddr,
    input  logic        apb_request__penable,
    input  logic        apb_request__psel,
    input  logic        apb_request__pwrite,
    input  logic [31:0] apb_request__pwdata,
    output logic [31:0] apb_response__prdata,
    output logic        apb_response__pready,
    output logic        apb_response__perr,
    output logic [31:0] stream_data,
    output logic        stream_valid,
    input  logic        stream_ack,
    output logic        fifo_low
);

    apb_request_t  req;
    apb_response_t rsp;
    reg_sel_e      sel;

    logic        access;
    logic        wr_data;
    logic        wr_control;
    logic        wr_threshold;
    logic        do_flush;
    logic        do_clr_ovf;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic [7:0]  fifo_level;
    logic [7:0]  fifo_level_next;
    logic        overflow;
    logic [7:0]  threshold_reg;
    logic [7:0]  threshold_next;
    logic        fifo_low_reg;
    logic        unused_addr_bits;

    assign req = '{paddr:   apb_request__paddr,
                   penable: apb_request__penable,
                   psel:    apb_request__psel,
                   pwrite:  apb_request__pwrite,
                   pwdata:  apb_request__pwdata};

    assign sel              = reg_sel_e'(req.paddr[3:2]);
    assign unused_addr_bits = &{1'b0, req.paddr[31:4], req.paddr[1:0]};

    assign pop = !fifo_empty && stream_ack;

`ifdef APB_STREAM_FIFO_WAIT_STATE_EN
    // Stall a DATA write while the FIFO is full and nothing leaves this cycle.
    assign rsp.pready = !(req.psel && req.penable && req.pwrite &&
                          (sel == REG_DATA) && fifo_full && !pop);
`else
    assign rsp.pready = 1'b1;
`endif
    assign rsp.perr = 1'b0;

    assign access       = req.psel && req.penable && rsp.pready;
    assign wr_data      = access && req.pwrite && (sel == REG_DATA);
    assign wr_control   = access && req.pwrite && (sel == REG_CONTROL);
    assign wr_threshold = access && req.pwrite && (sel == REG_THRESHOLD);
    assign do_flush     = wr_control && req.pwdata[CTRL_FLUSH_BIT];
    assign do_clr_ovf   = wr_control && req.pwdata[CTRL_CLR_OVF_BIT];

    fifo_sync_32 #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (clk__enable),
        .push       (wr_data),
        .push_data  (req.pwdata),
        .pop        (pop),
        .flush      (do_flush),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .level_next (fifo_level_next)
    );

`ifdef APB_STREAM_FIFO_WAIT_STATE_EN
    // Pushes never get dropped in this build, so there is nothing to flag.
    assign overflow = 1'b0;
    logic unused_clr_ovf;
    assign unused_clr_ovf = do_clr_ovf;
`else
    logic overflow_reg;

    // Sticky overflow: set by a dropped push, cleared only by CONTROL bit1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (clk__enable) begin
            if (do_clr_ovf) begin
                overflow_reg <= 1'b0;
            end else if (wr_data && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign overflow = overflow_reg;
`endif

    // Threshold next value, shared by the register and the fifo_low compare.
    always_comb begin
        threshold_next = threshold_reg;
        if (wr_threshold) threshold_next = req.pwdata[7:0];
    end

    // Threshold register and fifo_low, both tracking next-state values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            threshold_reg <= 8'd0;
            fifo_low_reg  <= 1'b1;
        end else if (clk__enable) begin
            threshold_reg <= threshold_next;
            fifo_low_reg  <= (fifo_level_next <= threshold_next);
        end
    end

    // Combinational read mux; returns 0 outside a read access.
    always_comb begin
        rsp.prdata = 32'd0;
        if (access && !req.pwrite) begin
            case (sel)
                REG_DATA:      rsp.prdata = fifo_head;
                REG_STATUS:    rsp.prdata = status_word(overflow, fifo_full, fifo_empty, fifo_level);
                REG_CONTROL:   rsp.prdata = 32'd0;
                REG_THRESHOLD: rsp.prdata = {24'd0, threshold_reg};
                default:       rsp.prdata = 32'd0;
            endcase
        end
    end

    assign apb_response__prdata = rsp.prdata;
    assign apb_response__pready = rsp.pready;
    assign apb_response__perr   = rsp.perr;
    assign stream_data          = fifo_head;
    assign stream_valid         = !fifo_empty;
    assign fifo_low             = fifo_low_reg;

endmodule
